// File: rtl/sub_byte_pipe.sv
// rtl/sub_byte_pipe.sv - multi-lane AES S-box (SubBytes / InvSubBytes) over a wide state
//
// Purpose: accepts one DATA_WIDTH state, substitutes LANES bytes per cycle
// (LSB group first) through shared-mode S-box lanes, then presents the result
// until the downstream takes it.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   sb_in_valid  in   input block valid
//   sb_in_ready  out  block can be accepted (IDLE, or DONE while result is taken)
//   sb_mode      in   0 = forward S-box, 1 = inverse S-box; sampled with the block
//   sb_data_in   in   input state, byte i at [8i+7:8i]
//   sb_out_valid out  result valid
//   sb_out_ready in   downstream accepts the result
//   sb_data_out  out  substituted state (result register)
//   sb_busy      out  high while substituting
module sub_byte_pipe #(
   parameter int DATA_WIDTH = 128,
   parameter int LANES      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sb_in_valid,
   output logic                  sb_in_ready,
   input  logic                  sb_mode,
   input  logic [DATA_WIDTH-1:0] sb_data_in,
   output logic                  sb_out_valid,
   input  logic                  sb_out_ready,
   output logic [DATA_WIDTH-1:0] sb_data_out,
   output logic                  sb_busy
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int NUM_STEPS = NUM_BYTES / LANES;
   localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [STEP_W-1:0]     r_step;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_mode;
   logic                  r_out_valid;

   logic [7:0] w_lane_in  [LANES];
   logic [7:0] w_lane_out [LANES];

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 == a^-1 for a != 0, and naturally yields 0 for a == 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
               ^ {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] a);
      return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   endfunction

   // One inverter per lane shared by both directions: the affine steps are
   // muxed around it rather than building two complete S-boxes.
   function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
      logic [7:0] t;
      logic [7:0] g;
      t = inv ? affine_inv(a) : a;
      g = gf_inv(t);
      return inv ? g : affine_fwd(g);
   endfunction

   // Group selection uses constant slices only; the step counter picks one.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_lane_in[l] = 8'h00;
         for (int s = 0; s < NUM_STEPS; s++) begin
            if (r_step == STEP_W'(s)) w_lane_in[l] = r_data[8*(s*LANES+l) +: 8];
         end
         w_lane_out[l] = sbox(w_lane_in[l], r_mode);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_step      <= '0;
         r_data      <= '0;
         r_mode      <= 1'b0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sb_in_valid) begin
                  r_data  <= sb_data_in;
                  r_mode  <= sb_mode;
                  r_step  <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               for (int b = 0; b < NUM_BYTES; b++) begin
                  if (r_step == STEP_W'(b / LANES)) r_result[8*b +: 8] <= w_lane_out[b % LANES];
               end
               if (r_step == LAST_STEP) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            S_DONE: begin
               if (sb_out_ready) begin
                  r_out_valid <= 1'b0;
                  if (sb_in_valid) begin
                     r_data  <= sb_data_in;
                     r_mode  <= sb_mode;
                     r_step  <= '0;
                     r_state <= S_BUSY;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign sb_in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && sb_out_ready);
   assign sb_busy      = (r_state == S_BUSY);
   assign sb_out_valid = r_out_valid;
   assign sb_data_out  = r_result;

endmodule

// File: tb/tb_sub_byte_pipe.sv
// tb/tb_sub_byte_pipe.sv - self-checking bench for sub_byte_pipe
module tb_sub_byte_pipe;

   localparam logic [127:0] V_PLAIN = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] V_SUB   = 128'h638293c31bfc33f5c4eeacea4bc12816;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         sb_in_valid = 1'b0;
   logic         sb_mode = 1'b0;
   logic [127:0] sb_data_in = '0;
   logic         sb_out_ready = 1'b0;

   logic         sb_in_ready, sb_out_valid, sb_busy;
   logic [127:0] sb_data_out;
   logic         l1_in_ready, l1_out_valid, l1_busy;
   logic [127:0] l1_data_out;
   logic         l16_in_ready, l16_out_valid, l16_busy;
   logic [127:0] l16_data_out;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] m_fwd [256];
   logic [7:0] m_inv [256];

   always #5 clk = ~clk;

   sub_byte_pipe dut (
      .clk(clk), .rst(rst), .sb_in_valid(sb_in_valid), .sb_in_ready(sb_in_ready),
      .sb_mode(sb_mode), .sb_data_in(sb_data_in), .sb_out_valid(sb_out_valid),
      .sb_out_ready(sb_out_ready), .sb_data_out(sb_data_out), .sb_busy(sb_busy)
   );

   sub_byte_pipe #(.DATA_WIDTH(128), .LANES(1)) u_l1 (
      .clk(clk), .rst(rst), .sb_in_valid(sb_in_valid), .sb_in_ready(l1_in_ready),
      .sb_mode(sb_mode), .sb_data_in(sb_data_in), .sb_out_valid(l1_out_valid),
      .sb_out_ready(sb_out_ready), .sb_data_out(l1_data_out), .sb_busy(l1_busy)
   );

   sub_byte_pipe #(.DATA_WIDTH(128), .LANES(16)) u_l16 (
      .clk(clk), .rst(rst), .sb_in_valid(sb_in_valid), .sb_in_ready(l16_in_ready),
      .sb_mode(sb_mode), .sb_data_in(sb_data_in), .sb_out_valid(l16_out_valid),
      .sb_out_ready(sb_out_ready), .sb_data_out(l16_data_out), .sb_busy(l16_busy)
   );

   // Reference S-box tables: brute-force inverse search plus bitwise affine map
   function automatic int m_mul(input int a, input int b);
      int p;
      int x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (((b >> i) & 1) == 1) p = p ^ x;
         x = x << 1;
         if ((x & 'h100) != 0) x = x ^ 'h11b;
      end
      return p;
   endfunction

   task automatic build_tables();
      logic [7:0] s;
      logic [7:0] b;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         s = 8'h00;
         for (int y = 1; y < 256; y++) if (m_mul(x, y) == 1) s = 8'(y);
         for (int i = 0; i < 8; i++)
            b[i] = s[i] ^ s[(i+4)%8] ^ s[(i+5)%8] ^ s[(i+6)%8] ^ s[(i+7)%8] ^ c[i];
         m_fwd[x] = b;
         m_inv[b] = 8'(x);
      end
   endtask

   function automatic logic [127:0] model_block(input logic [127:0] d, input logic m);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = m ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
      return r;
   endfunction

   // Presents a block and returns at the first negedge after it was taken
   task automatic accept(input logic [127:0] d, input logic m);
      int w;
      @(negedge clk);
      sb_in_valid = 1'b1;
      sb_data_in  = d;
      sb_mode     = m;
      w = 0;
      while (!sb_in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         n_fail++;
         $display("FAIL accept_timeout: sb_in_ready stayed %b, required 1", sb_in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      sb_in_valid = 1'b0;
   endtask

   // Called at the first negedge after accept; lat = edges until valid seen
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!sb_out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      sb_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sb_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (sb_out_valid !== 1'b0 || sb_data_out !== 128'h0 || sb_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b busy=%b data=%h, required 0/0/0", sb_out_valid, sb_busy, sb_data_out);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (sb_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b, required 1", sb_in_ready);
      end
   endtask

   task automatic test_lanes();
      int lat4, lat1, lat16;
      lat4 = -1; lat1 = -1; lat16 = -1;
      sb_in_valid = 1'b1; sb_data_in = V_PLAIN; sb_mode = 1'b0;
      @(posedge clk);
      @(negedge clk);
      sb_in_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (sb_out_valid && lat4 < 0) lat4 = c;
         if (l1_out_valid && lat1 < 0) lat1 = c;
         if (l16_out_valid && lat16 < 0) lat16 = c;
         @(negedge clk);
      end
      n_cmp += 3;
      if (lat4 != 4)   begin n_fail++; $display("FAIL lanes4_latency: got %0d, required 4", lat4); end
      if (lat1 != 16)  begin n_fail++; $display("FAIL lanes1_latency: got %0d, required 16", lat1); end
      if (lat16 != 1)  begin n_fail++; $display("FAIL lanes16_latency: got %0d, required 1", lat16); end
      n_cmp += 3;
      if (sb_data_out !== V_SUB)  begin n_fail++; $display("FAIL lanes4_data: got %h, required %h", sb_data_out, V_SUB); end
      if (l1_data_out !== V_SUB)  begin n_fail++; $display("FAIL lanes1_data: got %h, required %h", l1_data_out, V_SUB); end
      if (l16_data_out !== V_SUB) begin n_fail++; $display("FAIL lanes16_data: got %h, required %h", l16_data_out, V_SUB); end
      drain();
   endtask

   task automatic test_vectors();
      int lat;
      accept(V_PLAIN, 1'b0);
      wait_valid(lat);
      n_cmp += 2;
      if (lat != 4) begin n_fail++; $display("FAIL fwd_latency: got %0d, required 4", lat); end
      if (sb_data_out !== V_SUB) begin n_fail++; $display("FAIL fwd_vector: got %h, required %h", sb_data_out, V_SUB); end
      drain();
      n_cmp++;
      if (sb_out_valid !== 1'b0 || sb_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_to_idle: valid=%b in_ready=%b, required 0/1", sb_out_valid, sb_in_ready);
      end
      accept(V_SUB, 1'b1);
      wait_valid(lat);
      n_cmp++;
      if (sb_data_out !== V_PLAIN) begin n_fail++; $display("FAIL inv_vector: got %h, required %h", sb_data_out, V_PLAIN); end
      drain();
   endtask

   task automatic test_hold_back_to_back();
      int lat;
      accept(V_PLAIN, 1'b0);
      wait_valid(lat);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if (sb_data_out !== V_SUB || sb_in_ready !== 1'b0 || sb_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_stable: data=%h in_ready=%b valid=%b, required %h/0/1", sb_data_out, sb_in_ready, sb_out_valid, V_SUB);
         end
      end
      sb_out_ready = 1'b1; sb_in_valid = 1'b1; sb_data_in = '0; sb_mode = 1'b0;
      #1;
      n_cmp++;
      if (sb_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b, required 1", sb_in_ready); end
      @(posedge clk);
      @(negedge clk);
      sb_out_ready = 1'b0; sb_in_valid = 1'b0;
      n_cmp++;
      if (sb_out_valid !== 1'b0 || sb_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_busy: valid=%b busy=%b, required 0/1", sb_out_valid, sb_busy);
      end
      wait_valid(lat);
      n_cmp += 2;
      if (lat != 4) begin n_fail++; $display("FAIL b2b_latency: got %0d, required 4", lat); end
      if (sb_data_out !== {16{8'h63}}) begin n_fail++; $display("FAIL b2b_data: got %h, required %h", sb_data_out, {16{8'h63}}); end
      drain();
   endtask

   task automatic test_ignore_in_busy();
      logic [127:0] a;
      int c;
      a = {$urandom, $urandom, $urandom, $urandom};
      accept(a, 1'b1);
      sb_in_valid = 1'b1; sb_data_in = ~a; sb_mode = 1'b0;
      c = 0;
      while (!sb_out_valid && c < 100) begin
         n_cmp++;
         if (sb_in_ready !== 1'b0 || sb_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_ignore: in_ready=%b busy=%b, required 0/1", sb_in_ready, sb_busy);
         end
         @(negedge clk);
         c++;
      end
      sb_in_valid = 1'b0;
      n_cmp++;
      if (sb_data_out !== model_block(a, 1'b1)) begin
         n_fail++;
         $display("FAIL busy_ignore_data: got %h, required %h", sb_data_out, model_block(a, 1'b1));
      end
      drain();
      sb_out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (sb_out_valid !== 1'b0 || sb_data_out !== model_block(a, 1'b1)) begin
            n_fail++;
            $display("FAIL idle_out_ready: valid=%b data=%h, required 0/%h", sb_out_valid, sb_data_out, model_block(a, 1'b1));
         end
      end
      sb_out_ready = 1'b0;
   endtask

   task automatic test_exhaustive();
      int lat;
      logic [7:0] v;
      logic [7:0] e;
      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 256; x++) begin
            v = 8'(x);
            e = (m == 1) ? m_inv[v] : m_fwd[v];
            accept({16{v}}, m[0]);
            wait_valid(lat);
            n_cmp++;
            if (sb_data_out !== {16{e}} || lat != 4) begin
               n_fail++;
               $display("FAIL exhaustive mode=%0d in=%h: got %h lat=%0d, required %h lat=4", m, v, sb_data_out, lat, {16{e}});
            end
            drain();
         end
      end
   endtask

   task automatic test_random();
      int lat;
      logic [127:0] d;
      logic [127:0] e;
      logic m;
      for (int it = 0; it < 40; it++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         m = 1'($urandom_range(0, 1));
         e = model_block(d, m);
         accept(d, m);
         wait_valid(lat);
         n_cmp++;
         if (sb_data_out !== e || lat != 4) begin
            n_fail++;
            $display("FAIL random[%0d] mode=%b: got %h lat=%0d, required %h lat=4", it, m, sb_data_out, lat, e);
         end
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            n_cmp++;
            if (sb_data_out !== e || sb_out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL random_hold[%0d]: data=%h valid=%b, required %h/1", it, sb_data_out, sb_out_valid, e);
            end
         end
         drain();
      end
   endtask

   task automatic test_reset_mid_busy();
      accept(V_PLAIN, 1'b0);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (sb_busy !== 1'b1 || sb_data_out === 128'h0) begin
         n_fail++;
         $display("FAIL mid_busy_partial: busy=%b data=%h, required busy 1 with partial data", sb_busy, sb_data_out);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (sb_out_valid !== 1'b0 || sb_data_out !== 128'h0 || sb_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_busy_reset: valid=%b busy=%b data=%h, required 0/0/0", sb_out_valid, sb_busy, sb_data_out);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (sb_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b, required 1", sb_in_ready); end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if (sb_out_valid !== 1'b0 || sb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: valid=%b busy=%b, required 0/0", sb_out_valid, sb_busy);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      build_tables();
      test_reset();
      test_lanes();
      test_vectors();
      test_hold_back_to_back();
      test_ignore_in_busy();
      test_exhaustive();
      test_random();
      test_reset_mid_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sub_byte_pipe.md
SUB_BYTE_PIPE -- requirements
Module: sub_byte_pipe

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, default 128: state width in bits; a multiple of 8.
- LANES, default 4: bytes substituted per cycle; a power of 2 that divides DATA_WIDTH/8.
REQ-002 The block SHALL derive these local parameters:
- NUM_BYTES = DATA_WIDTH/8.
- NUM_STEPS = NUM_BYTES/LANES.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- sb_in_valid  input  1  input block valid.
- sb_in_ready  output  1  block can accept input.
- sb_mode  input  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt); sampled with the input block.
- sb_data_in  input  DATA_WIDTH  input state; byte i occupies bits [8i+7:8i].
- sb_out_valid  output  1  result valid.
- sb_out_ready  input  1  downstream accepts the result.
- sb_data_out  output  DATA_WIDTH  substituted state.
- sb_busy  output  1  high in BUSY.

Function
REQ-004 Input transfer SHALL occur on a rising edge where sb_in_valid && sb_in_ready; output transfer SHALL occur on a rising edge where sb_out_valid && sb_out_ready.
REQ-005 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-006 sb_in_ready SHALL be combinational: (state==IDLE) || (state==DONE && sb_out_ready).
REQ-007 On input transfer the block SHALL capture sb_data_in and sb_mode into internal registers, clear the step counter to 0 and enter BUSY; after capture, sb_data_in and sb_mode are don't-care.
REQ-008 In BUSY, each cycle SHALL substitute the LANES bytes with indices [step*LANES, step*LANES+LANES-1] of the captured state and write them into the same byte positions of the result register.
REQ-009 Bytes SHALL be processed from step 0 (LSB bytes) upward, and the step counter SHALL increment by 1 per BUSY cycle.
REQ-010 When step == NUM_STEPS-1, the block SHALL write the final group, enter DONE and assert sb_out_valid on the next cycle.
REQ-011 Latency from the input-transfer edge to sb_out_valid high SHALL be exactly NUM_STEPS cycles, with no stalls inside BUSY.
REQ-012 When LANES == NUM_BYTES, the block SHALL spend a single BUSY cycle and the latency SHALL be 1.
REQ-013 In DONE, sb_out_valid SHALL be 1 and sb_data_out SHALL hold steady until output transfer.
REQ-014 On output transfer without a simultaneous input transfer, the block SHALL go to IDLE and deassert sb_out_valid on the next cycle.
REQ-015 On simultaneous output and input transfer in DONE, the block SHALL capture the new block and go directly to BUSY, giving one block per NUM_STEPS+1 cycles.
REQ-016 sb_data_out SHALL be driven from the result register and SHALL keep its last value in IDLE and BUSY; only sb_out_valid qualifies it.
REQ-017 The forward S-box SHALL be the FIPS-197 SubBytes mapping and the inverse S-box SHALL be the FIPS-197 InvSubBytes mapping, each implemented as GF(2^8) inversion (polynomial 0x11B, 0 maps to 0) combined with the affine transform or its inverse, in combinational logic with no ROM or initial-file dependence.
REQ-018 All LANES substitution lanes SHALL share the captured mode, and mode SHALL be constant for the whole block.
REQ-019 sb_in_valid asserted in BUSY SHALL be ignored (sb_in_ready = 0), and the upstream SHALL hold it.
REQ-020 sb_out_ready asserted while sb_out_valid = 0 SHALL have no effect.
REQ-021 sb_busy SHALL be 1 exactly when state == BUSY.

Reset
REQ-022 While rst = 0, the block SHALL asynchronously force state = IDLE, step counter = 0, sb_out_valid = 0, captured data/mode = 0 and sb_data_out = 0.
REQ-023 Reset asserted in BUSY or DONE SHALL discard the partial or pending result, and no sb_out_valid pulse SHALL appear after reset release.
REQ-024 After reset release, sb_in_ready SHALL be 1 on the first clock.

Verification
REQ-025 With defaults, mode 0, input 128'h00112233445566778899aabbccddeeff: sb_out_valid rises exactly 4 cycles after accept with sb_data_out = 128'h638293c31bfc33f5c4eeacea4bc12816.
REQ-026 Mode 1 with input 128'h638293c31bfc33f5c4eeacea4bc12816 SHALL yield 128'h00112233445566778899aabbccddeeff.
REQ-027 With sb_out_ready held 0 for 10 cycles after sb_out_valid rises, sb_data_out is stable and sb_in_ready = 0 throughout. Raising sb_out_ready together with sb_in_valid (data all-0x00, mode 0) then gives a result of all-0x63 four cycles later.
REQ-028 Exhaustive check over all 256 byte values in both modes (replicated in every lane) SHALL match the FIPS-197 tables; this covers 0x00->0x63, 0x53->0xED and inverse 0xED->0x53.
REQ-029 Driving rst low in the middle of BUSY (step 2) SHALL immediately clear sb_out_valid and sb_data_out to 0, and no output SHALL appear after release until a new block is accepted.
REQ-030 Builds with LANES = 1, 16 and 4 SHALL give latencies of 16, 1 and 4 cycles respectively, each with an identical result for REQ-025.
